uart_receiver: RTL and testbench

//  Serial-to-parallel receive engine of the APB UART; counterpart of the transmit engine.

---
 rtl/uart_receiver.sv | 218 +++++++++++++++++++++
 tb/tb_uart_receiver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// uart_receiver: serial-to-parallel receive engine of the APB UART.
// SIN is synchronised, then oversampled on the 16x RXCLK enable. A start bit
// is confirmed at mid-bit, 5..8 data bits are shifted LSB first, followed by an
// optional parity bit and one stop bit. Framing error and break are flagged.
//
// Output handshake: RXFINISHED is a valid-only strobe with no ready/backpressure.
// It is high for exactly one CLK, and in that cycle DOUT/PE/FE/BI carry the new
// character. Those outputs then hold until the next strobe, so a consumer that
// samples on the strobe cycle always sees a consistent set.
//
// STATE exposes the FSM encoding for debug and checker binding.
module uart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       RXCLEAR,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       SIN,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_BRKWAIT = 3'd5
  } state_t;

  state_t                 state_q, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sin_s;

  logic [3:0] tick_q, tick_n;
  logic [2:0] bitcnt_q, bitcnt_n;
  logic [7:0] shift_q, shift_n;
  logic       any_one_q, any_one_n;   // any sampled bit of this frame was 1
  logic       perr_q, perr_n;

  // Frame configuration captured when the start bit is confirmed
  logic [1:0] wls_q, wls_n;
  logic       pen_q, pen_n;
  logic       eps_q, eps_n;
  logic       sp_q, sp_n;

  logic [7:0] dout_n;
  logic       pe_n, fe_n, bi_n, fin_n;

  logic [2:0] last_bit;
  logic       par_exp;

  assign sin_s    = sync_q[SYNC_STAGES-1];
  assign last_bit = {1'b0, wls_q} + 3'd4;
  assign STATE    = state_q;

  // Stick parity forces a constant; otherwise even/odd over the data bits.
  // Bits above the word length are held at 0 so they do not disturb the XOR.
  assign par_exp = sp_q ? ~eps_q : (eps_q ? ^shift_q : ~(^shift_q));

  // Metastability synchroniser on the asynchronous serial input; idles high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], SIN};
  end

  // State, counters, frame datapath and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      tick_q     <= 4'd0;
      bitcnt_q   <= 3'd0;
      shift_q    <= 8'd0;
      any_one_q  <= 1'b0;
      perr_q     <= 1'b0;
      wls_q      <= 2'd0;
      pen_q      <= 1'b0;
      eps_q      <= 1'b0;
      sp_q       <= 1'b0;
      DOUT       <= 8'd0;
      PE         <= 1'b0;
      FE         <= 1'b0;
      BI         <= 1'b0;
      RXFINISHED <= 1'b0;
    end else begin
      state_q    <= state_n;
      tick_q     <= tick_n;
      bitcnt_q   <= bitcnt_n;
      shift_q    <= shift_n;
      any_one_q  <= any_one_n;
      perr_q     <= perr_n;
      wls_q      <= wls_n;
      pen_q      <= pen_n;
      eps_q      <= eps_n;
      sp_q       <= sp_n;
      DOUT       <= dout_n;
      PE         <= pe_n;
      FE         <= fe_n;
      BI         <= bi_n;
      RXFINISHED <= fin_n;
    end
  end

  // Next-state and datapath: everything advances only on an RXCLK enable,
  // and RXCLEAR overrides it, discarding any coincident tick
  always_comb begin
    state_n   = state_q;
    tick_n    = tick_q;
    bitcnt_n  = bitcnt_q;
    shift_n   = shift_q;
    any_one_n = any_one_q;
    perr_n    = perr_q;
    wls_n     = wls_q;
    pen_n     = pen_q;
    eps_n     = eps_q;
    sp_n      = sp_q;
    dout_n    = DOUT;
    pe_n      = PE;
    fe_n      = FE;
    bi_n      = BI;
    fin_n     = 1'b0;

    if (RXCLEAR) begin
      state_n  = S_IDLE;
      tick_n   = 4'd0;
      bitcnt_n = 3'd0;
    end else if (RXCLK) begin
      case (state_q)
        S_IDLE: begin
          if (!sin_s) begin
            state_n = S_START;
            tick_n  = 4'd1;
          end
        end

        S_START: begin
          if (tick_q == 4'd8) begin
            if (sin_s) begin
              // Low pulse shorter than half a bit: treat as noise
              state_n = S_IDLE;
              tick_n  = 4'd0;
            end else begin
              state_n   = S_DATA;
              tick_n    = 4'd0;
              bitcnt_n  = 3'd0;
              shift_n   = 8'd0;
              any_one_n = 1'b0;
              perr_n    = 1'b0;
              wls_n     = WLS;
              pen_n     = PEN;
              eps_n     = EPS;
              sp_n      = SP;
            end
          end else begin
            tick_n = tick_q + 4'd1;
          end
        end

        S_DATA: begin
          tick_n = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            shift_n[bitcnt_q] = sin_s;
            any_one_n         = any_one_q | sin_s;
            if (bitcnt_q == last_bit) begin
              bitcnt_n = 3'd0;
              state_n  = pen_q ? S_PARITY : S_STOP;
            end else begin
              bitcnt_n = bitcnt_q + 3'd1;
            end
          end
        end

        S_PARITY: begin
          tick_n = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            perr_n    = (sin_s != par_exp);
            any_one_n = any_one_q | sin_s;
            state_n   = S_STOP;
          end
        end

        S_STOP: begin
          tick_n = tick_q + 4'd1;
          if (tick_q == 4'd15) begin
            fin_n   = 1'b1;
            dout_n  = shift_q;
            pe_n    = perr_q;
            fe_n    = ~sin_s;
            bi_n    = ~sin_s & ~any_one_q;
            tick_n  = 4'd0;
            state_n = sin_s ? S_IDLE : S_BRKWAIT;
          end
        end

        S_BRKWAIT: begin
          // A held-low line must not be mistaken for a fresh start bit
          if (sin_s) state_n = S_IDLE;
        end

        default: begin
          state_n = S_IDLE;
          tick_n  = 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed vector table of frames plus hand-written
// sequences for glitch, break, RXCLEAR and mid-frame reset.
module tb_uart_receiver;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RXCLK;
  logic       RXCLEAR;
  logic [1:0] WLS;
  logic       PEN, EPS, SP;
  logic       SIN;
  logic [7:0] DOUT;
  logic       PE, FE, BI, RXFINISHED;
  logic [2:0] STATE;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BRKWAIT = 3'd5;

  int tests = 0;
  int fails = 0;

  logic [10:0] exp_q[$];   // {dout, pe, fe, bi}
  logic [10:0] got_q[$];

  typedef struct {
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       mangle;
    logic [7:0] e_dout;
    logic       e_pe;
    logic       e_fe;
    logic       e_bi;
  } vec_t;

  vec_t vecs[12];

  uart_receiver #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .RXCLEAR(RXCLEAR),
    .WLS(WLS), .PEN(PEN), .EPS(EPS), .SP(SP), .SIN(SIN),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI),
    .RXFINISHED(RXFINISHED), .STATE(STATE)
  );

  // Clock
  always #5 CLK = ~CLK;

  // Capture every strobe cycle; a stretched pulse yields extra entries
  always @(negedge CLK) begin
    if (RXFINISHED === 1'b1) got_q.push_back({DOUT, PE, FE, BI});
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One RXCLK enable pulse, spaced 3 CLKs apart
  task automatic rx_tick();
    @(negedge CLK) RXCLK = 1'b1;
    @(negedge CLK) RXCLK = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    SIN = b;
    repeat (16) rx_tick();
  endtask

  task automatic idle(input int n);
    SIN = 1'b1;
    repeat (n) rx_tick();
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic pen,
                            input logic par, input logic stop, input logic mangle);
    send_bit(1'b0);
    if (mangle) begin
      WLS = ~WLS; PEN = ~PEN; EPS = ~EPS; SP = ~SP;
    end
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
    if (pen) send_bit(par);
    send_bit(stop);
    idle(4);
  endtask

  // Compare the single expected frame against what the monitor captured
  task automatic check_frame(input string name);
    logic [10:0] e, g;
    e = exp_q.pop_front();
    chk({name, " strobes"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      g = got_q.pop_front();
      chk({name, " dout"}, {24'd0, g[10:3]}, {24'd0, e[10:3]});
      chk({name, " pe"},   {31'd0, g[2]},    {31'd0, e[2]});
      chk({name, " fe"},   {31'd0, g[1]},    {31'd0, e[1]});
      chk({name, " bi"},   {31'd0, g[0]},    {31'd0, e[0]});
    end
    got_q.delete();
  endtask

  task automatic cfg_8n1();
    WLS = 2'b11; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
  endtask

  // Start bit, data bits 0..2, then half of bit 3 of 0x7E
  task automatic partial_frame();
    logic [7:0] d;
    d = 8'h7E;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    SIN = d[3];
    repeat (8) rx_tick();
  endtask

  initial begin
    vecs[0]  = '{2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 1'b1, 1'b0, 8'h13, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 1'b1, 1'b1, 1'b0, 8'h13, 1'b1, 1'b1, 1'b0, 8'h13, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{2'b10, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b10, 1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{2'b01, 1'b1, 1'b0, 1'b0, 8'h2A, 1'b0, 1'b1, 1'b0, 8'h2A, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h1F, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'b11, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{2'b10, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

    // Reset
    RST = 1'b1; RXCLK = 1'b0; RXCLEAR = 1'b0; SIN = 1'b1;
    cfg_8n1();
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset dout",  {24'd0, DOUT}, 32'd0);
    chk("reset flags", {28'd0, PE, FE, BI, RXFINISHED}, 32'd0);
    chk("reset state", {29'd0, STATE}, {29'd0, ST_IDLE});
    idle(4);

    // Frame table
    for (int v = 0; v < 12; v++) begin
      WLS = vecs[v].wls; PEN = vecs[v].pen; EPS = vecs[v].eps; SP = vecs[v].sp;
      exp_q.push_back({vecs[v].e_dout, vecs[v].e_pe, vecs[v].e_fe, vecs[v].e_bi});
      send_frame(vecs[v].data, int'(vecs[v].wls) + 5, vecs[v].pen, vecs[v].par,
                 vecs[v].stop, vecs[v].mangle);
      check_frame($sformatf("vec%0d", v));
      chk($sformatf("vec%0d idle", v), {29'd0, STATE}, {29'd0, ST_IDLE});
    end

    // Short low glitch is rejected, then a clean frame follows
    cfg_8n1();
    SIN = 1'b0;
    repeat (4) rx_tick();
    idle(20);
    chk("glitch strobes", got_q.size(), 0);
    chk("glitch state", {29'd0, STATE}, {29'd0, ST_IDLE});
    got_q.delete();
    exp_q.push_back({8'h3C, 1'b0, 1'b0, 1'b0});
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("after glitch");

    // Long break: one result, then wait for line high before another frame
    exp_q.push_back({8'h00, 1'b0, 1'b1, 1'b1});
    SIN = 1'b0;
    repeat (25 * 16) rx_tick();
    chk("break state", {29'd0, STATE}, {29'd0, ST_BRKWAIT});
    check_frame("break");
    idle(4);
    chk("break release", {29'd0, STATE}, {29'd0, ST_IDLE});
    exp_q.push_back({8'h81, 1'b0, 1'b0, 1'b0});
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("after break");

    // RXCLEAR (coincident with RXCLK) in data bit 3
    partial_frame();
    @(negedge CLK) begin RXCLK = 1'b1; RXCLEAR = 1'b1; end
    @(negedge CLK) begin RXCLK = 1'b0; RXCLEAR = 1'b0; end
    chk("clear state", {29'd0, STATE}, {29'd0, ST_IDLE});
    idle(12 * 16);
    chk("clear strobes", got_q.size(), 0);
    chk("clear dout kept", {24'd0, DOUT}, 32'h81);
    got_q.delete();
    exp_q.push_back({8'h7E, 1'b0, 1'b0, 1'b0});
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("after clear");

    // Reset in data bit 3
    partial_frame();
    @(negedge CLK) RST = 1'b1;
    @(negedge CLK);
    chk("rst dout",  {24'd0, DOUT}, 32'd0);
    chk("rst flags", {28'd0, PE, FE, BI, RXFINISHED}, 32'd0);
    chk("rst state", {29'd0, STATE}, {29'd0, ST_IDLE});
    RST = 1'b0;
    idle(12 * 16);
    chk("rst strobes", got_q.size(), 0);
    got_q.delete();
    exp_q.push_back({8'h7E, 1'b0, 1'b0, 1'b0});
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    check_frame("after rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
